sdram_arb_rr: RTL and testbench
===============================

Name: sdram_arb_rr

Overview:
- Parametrised N-port arbiter in front of the single-command SDRAM core interface. Successor to the fixed two-port arbiter.
- Grants the core to one requesting port at a time and holds that grant until the core acks the transaction.
- Supports fixed or round-robin priority; registered grant with 1-cycle arbitration latency.
- Sits between DMA/CPU/video masters and the SDRAM controller core.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- LEN_W, 8, burst length field width.
- ROUND_ROBIN, 1, 1 = rotating priority, 0 = fixed priority (port 0 highest).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with SDRAM_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- port_wr_i  in  NUM_PORTS*(DATA_W/8)  per-port byte write strobes; port p occupies slice p.
- port_rd_i  in  NUM_PORTS  per-port read request.
- port_len_i  in  NUM_PORTS*LEN_W  per-port burst length.
- port_addr_i  in  NUM_PORTS*ADDR_W  per-port address.
- port_write_data_i  in  NUM_PORTS*DATA_W  per-port write data.
- port_accept_o  out  NUM_PORTS  command accepted, routed to owner only.
- port_ack_o  out  NUM_PORTS  command completed, routed to owner only.
- port_error_o  out  NUM_PORTS  error, routed to owner only.
- port_read_data_o  out  NUM_PORTS*DATA_W  read data; owner gets core data, all other ports get 0.
- core_wr_o  out  DATA_W/8  core write strobes.
- core_rd_o  out  1  core read request.
- core_len_o  out  LEN_W  core burst length.
- core_addr_o  out  ADDR_W  core address.
- core_write_data_o  out  DATA_W  core write data.
- core_accept_i  in  1  core accepted command.
- core_ack_i  in  1  core completed command.
- core_error_i  in  1  core error.
- core_read_data_i  in  DATA_W  core read data.
- busy_o  out  1  a grant is held.
- owner_o  out  $clog2(NUM_PORTS)  index of the current owner; valid when busy_o=1.

Behaviour:
- Request: req[p] = port_rd_i[p] | (port_wr_i slice p != 0).
- Two states: IDLE and BUSY.
- Reset: state=IDLE, owner=0, rr_last=NUM_PORTS-1. All outputs 0.
- IDLE, any req: pick winner combinationally.
  - ROUND_ROBIN=1: first requesting port searching upward from rr_last+1, wrapping modulo NUM_PORTS.
  - ROUND_ROBIN=0: lowest-index requester.
  - Next cycle: state=BUSY, owner=winner, rr_last=winner.
- IDLE drives all core_* outputs to 0; nothing reaches the core in the arbitration cycle. Request-to-core latency is 1 cycle.
- BUSY: core_* outputs equal the owner's port inputs, combinationally.
- BUSY: port_accept_o/ack_o/error_o/read_data_o of the owner mirror the core inputs; all other ports see 0.
- BUSY and core_ack_i: the owner sees the ack that cycle.
  - Arbitration runs in the same cycle, excluding the current owner's req.
  - If another port requests: next cycle BUSY with the new owner (back-to-back, no idle bubble).
  - Otherwise: next cycle IDLE.
  - The excluded owner may re-win only from a later arbitration.
- Owner must hold its command stable until ack. If the owner drops its request before ack, the grant is still held and core_* follow the (now zero) inputs. This is a protocol violation and is not detected.
- core_accept_i/ack_i/error_i in IDLE are ignored; no port sees them.
- Requests arriving while BUSY wait; no port starves under ROUND_ROBIN=1. Worst-case wait is NUM_PORTS-1 transactions.
- Reset mid-transaction: returns to IDLE next cycle; outputs 0. The in-flight core transaction is abandoned; the core is reset by the same rst_i.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- With it defined:
  - A counter clears on each grant and increments every BUSY cycle without core_ack_i.
  - When it reaches TIMEOUT_CYCLES-1, the owner gets port_ack_o=1 and port_error_o=1 for one cycle. The grant is released next cycle exactly as on core_ack_i.
  - A sticky timeout_o output (1 bit, cleared only by reset) is added.
- Without it: no counter and no timeout_o port; the grant is held indefinitely until core_ack_i.

Test Plan:
- Port 2 only, rd, addr 0x100, NUM_PORTS=4 → core_rd_o=1 and core_addr_o=0x100 one cycle after the request. Core ack 5 cycles later → port_ack_o=4'b0100 that cycle, then IDLE.
- Ports 0,1,3 request simultaneously, ROUND_ROBIN=1, core acks each after 3 cycles → grant order 0,1,3. Re-request of all → order 0,1,3 again with rr wrap, no idle cycles between grants.
- Same stimulus, ROUND_ROBIN=0, port 0 re-requests immediately after each ack → grants alternate 0,1,0,3… Port 0 is never granted twice in a row.
- Core asserts core_ack_i and core_accept_i while IDLE → all port_* outputs stay 0; state stays IDLE.
- rst_i pulsed while port 1 is owner, mid-burst → next cycle busy_o=0, all outputs 0. Re-arbitration starts with port 0 first (rr_last reset).
- SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never acks → owner sees ack+error in the 16th BUSY cycle, timeout_o=1, next waiting port is granted the following cycle.

Source files
------------

// File: rtl/sdram_arb_rr.sv
// sdram_arb_rr: N-port arbiter in front of the single-command SDRAM core.
// One requesting port owns the core from grant until the core acks; owner
// selection is fixed priority (port 0 highest) or rotating, with a
// registered grant (one cycle from request to core).
// Optional macro SDRAM_ARB_TIMEOUT_EN adds a watchdog that force-completes
// a stuck transaction with ack+error and a sticky timeout_o flag.
//
// Handshake: a port requests by holding port_rd_i or any port_wr_i strobe
// and must keep its whole command stable until it sees port_ack_o. The
// owner sees core accept/ack/error/read data mirrored onto its own port;
// every other port sees zeros. A port_ack_o pulse is the only completion
// event and lasts exactly one cycle.
module sdram_arb_rr #(
   parameter int NUM_PORTS      = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int LEN_W          = 8,
   parameter int ROUND_ROBIN    = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_PORTS*(DATA_W/8)-1:0] port_wr_i,
   input  logic [NUM_PORTS-1:0]            port_rd_i,
   input  logic [NUM_PORTS*LEN_W-1:0]      port_len_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]     port_addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]     port_write_data_i,
   output logic [NUM_PORTS-1:0]            port_accept_o,
   output logic [NUM_PORTS-1:0]            port_ack_o,
   output logic [NUM_PORTS-1:0]            port_error_o,
   output logic [NUM_PORTS*DATA_W-1:0]     port_read_data_o,
   output logic [DATA_W/8-1:0]             core_wr_o,
   output logic                            core_rd_o,
   output logic [LEN_W-1:0]                core_len_o,
   output logic [ADDR_W-1:0]               core_addr_o,
   output logic [DATA_W-1:0]               core_write_data_o,
   input  logic                            core_accept_i,
   input  logic                            core_ack_i,
   input  logic                            core_error_i,
   input  logic [DATA_W-1:0]               core_read_data_i,
   output logic                            busy_o,
   output logic [$clog2(NUM_PORTS)-1:0]    owner_o
`ifdef SDRAM_ARB_TIMEOUT_EN
   ,
   output logic                            timeout_o
`endif
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OWN_W  = $clog2(NUM_PORTS);

   // busy_o is the external view of this state register.
   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t             state_q, state_d;
   logic [OWN_W-1:0]   owner_q, owner_d;
   logic [OWN_W-1:0]   rr_last_q, rr_last_d;

   logic [NUM_PORTS-1:0] req;
   logic [NUM_PORTS-1:0] cand;
   logic                 found;
   logic [OWN_W-1:0]     win;
   logic                 tmo_hit;
   logic                 rel;

   // A port requests when it reads or drives any write strobe.
   always_comb begin
      req = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req[p] = port_rd_i[p] | (|port_wr_i[p*STRB_W +: STRB_W]);
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   assign tmo_hit   = (state_q == ST_BUSY) && !core_ack_i &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o = timeout_q;

   // Watchdog: counts un-acked busy cycles since the current grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == ST_BUSY && !rel) cnt_q <= cnt_q + 1'b1;
         else                            cnt_q <= '0;
         if (tmo_hit) timeout_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // The grant ends on a core ack or a watchdog expiry.
   assign rel = core_ack_i | tmo_hit;

   // Winner search; a releasing owner is masked so it cannot re-win at once.
   always_comb begin
      int base;
      int idx;
      cand = req;
      if (state_q == ST_BUSY) cand[owner_q] = 1'b0;
      base = 0;
      if (ROUND_ROBIN != 0) begin
         base = int'(rr_last_q) + 1;
         if (base >= NUM_PORTS) base = 0;
      end
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = base + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = OWN_W'(idx);
         end
      end
   end

   // State, owner and rotation pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         rr_last_q <= OWN_W'(NUM_PORTS - 1);
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
      end
   end

   // Next state: grant from IDLE, or hand over / go idle on release.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d   = ST_BUSY;
               owner_d   = win;
               rr_last_d = win;
            end
         end
         ST_BUSY: begin
            if (rel) begin
               if (found) begin
                  owner_d   = win;
                  rr_last_d = win;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath muxing: only the owner reaches the core and sees responses.
   always_comb begin
      core_wr_o         = '0;
      core_rd_o         = 1'b0;
      core_len_o        = '0;
      core_addr_o       = '0;
      core_write_data_o = '0;
      port_accept_o     = '0;
      port_ack_o        = '0;
      port_error_o      = '0;
      port_read_data_o  = '0;
      if (state_q == ST_BUSY) begin
         core_wr_o         = port_wr_i[int'(owner_q)*STRB_W +: STRB_W];
         core_rd_o         = port_rd_i[owner_q];
         core_len_o        = port_len_i[int'(owner_q)*LEN_W +: LEN_W];
         core_addr_o       = port_addr_i[int'(owner_q)*ADDR_W +: ADDR_W];
         core_write_data_o = port_write_data_i[int'(owner_q)*DATA_W +: DATA_W];
         port_accept_o[owner_q] = core_accept_i;
         port_ack_o[owner_q]    = core_ack_i | tmo_hit;
         port_error_o[owner_q]  = core_error_i | tmo_hit;
         port_read_data_o[int'(owner_q)*DATA_W +: DATA_W] = core_read_data_i;
      end
   end

   assign busy_o  = (state_q == ST_BUSY);
   assign owner_o = owner_q;

endmodule

// File: tb/tb_sdram_arb_rr.sv
// tb_sdram_arb_rr: two arbiters (rotating and fixed priority) share port
// and core stimulus; each is held in reset while the other is exercised.
// Completions are predicted into per-instance queues and checked by monitors.
module tb_sdram_arb_rr;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int SW = DW / 8;
   localparam int RW = NP*DW + 2*NP;

   logic clk = 1'b0;
   logic rst_rr, rst_fx;
   logic use_fx;
   int   checks = 0;
   int   errors = 0;

   logic [NP*SW-1:0] port_wr;
   logic [NP-1:0]    port_rd;
   logic [NP*LW-1:0] port_len;
   logic [NP*AW-1:0] port_addr;
   logic [NP*DW-1:0] port_wdata;
   logic             c_accept, c_ack, c_err;
   logic [DW-1:0]    c_rdata;

   logic [NP-1:0]    rr_accept, rr_ack, rr_err, fx_accept, fx_ack, fx_err;
   logic [NP*DW-1:0] rr_rdata, fx_rdata;
   logic [SW-1:0]    rr_cwr, fx_cwr;
   logic             rr_crd, fx_crd, rr_busy, fx_busy;
   logic [LW-1:0]    rr_clen, fx_clen;
   logic [AW-1:0]    rr_caddr, fx_caddr;
   logic [DW-1:0]    rr_cwd, fx_cwd;
   logic [1:0]       rr_owner, fx_owner;
`ifdef SDRAM_ARB_TIMEOUT_EN
   logic             rr_timeout, fx_timeout;
`endif

   logic [RW-1:0] exp_rr_q[$];
   logic [RW-1:0] exp_fx_q[$];

   logic             rd_tab[NP];
   logic [SW-1:0]    wr_tab[NP];
   logic [LW-1:0]    len_tab[NP];
   logic [AW-1:0]    addr_tab[NP];
   logic [DW-1:0]    wd_tab[NP];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   sdram_arb_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
                  .ROUND_ROBIN(1), .TIMEOUT_CYCLES(16)) dut_rr (
      .clk_i(clk), .rst_i(rst_rr),
      .port_wr_i(port_wr), .port_rd_i(port_rd), .port_len_i(port_len),
      .port_addr_i(port_addr), .port_write_data_i(port_wdata),
      .port_accept_o(rr_accept), .port_ack_o(rr_ack), .port_error_o(rr_err),
      .port_read_data_o(rr_rdata),
      .core_wr_o(rr_cwr), .core_rd_o(rr_crd), .core_len_o(rr_clen),
      .core_addr_o(rr_caddr), .core_write_data_o(rr_cwd),
      .core_accept_i(c_accept), .core_ack_i(c_ack), .core_error_i(c_err),
      .core_read_data_i(c_rdata),
      .busy_o(rr_busy), .owner_o(rr_owner)
`ifdef SDRAM_ARB_TIMEOUT_EN
      , .timeout_o(rr_timeout)
`endif
   );

   sdram_arb_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
                  .ROUND_ROBIN(0), .TIMEOUT_CYCLES(16)) dut_fx (
      .clk_i(clk), .rst_i(rst_fx),
      .port_wr_i(port_wr), .port_rd_i(port_rd), .port_len_i(port_len),
      .port_addr_i(port_addr), .port_write_data_i(port_wdata),
      .port_accept_o(fx_accept), .port_ack_o(fx_ack), .port_error_o(fx_err),
      .port_read_data_o(fx_rdata),
      .core_wr_o(fx_cwr), .core_rd_o(fx_crd), .core_len_o(fx_clen),
      .core_addr_o(fx_caddr), .core_write_data_o(fx_cwd),
      .core_accept_i(c_accept), .core_ack_i(c_ack), .core_error_i(c_err),
      .core_read_data_i(c_rdata),
      .busy_o(fx_busy), .owner_o(fx_owner)
`ifdef SDRAM_ARB_TIMEOUT_EN
      , .timeout_o(fx_timeout)
`endif
   );

   // Outputs of whichever instance is under test.
   wire [NP-1:0]    s_accept = use_fx ? fx_accept : rr_accept;
   wire [NP-1:0]    s_ack    = use_fx ? fx_ack    : rr_ack;
   wire [NP-1:0]    s_err    = use_fx ? fx_err    : rr_err;
   wire [NP*DW-1:0] s_rdata  = use_fx ? fx_rdata  : rr_rdata;
   wire [SW-1:0]    s_cwr    = use_fx ? fx_cwr    : rr_cwr;
   wire             s_crd    = use_fx ? fx_crd    : rr_crd;
   wire [LW-1:0]    s_clen   = use_fx ? fx_clen   : rr_clen;
   wire [AW-1:0]    s_caddr  = use_fx ? fx_caddr  : rr_caddr;
   wire [DW-1:0]    s_cwd    = use_fx ? fx_cwd    : rr_cwd;
   wire             s_busy   = use_fx ? fx_busy   : rr_busy;
   wire [1:0]       s_owner  = use_fx ? fx_owner  : rr_owner;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] ack_rec(input int p, input logic err, input logic [DW-1:0] d);
      logic [NP-1:0]    a;
      logic [NP-1:0]    e;
      logic [NP*DW-1:0] rv;
      a = '0;
      a[p] = 1'b1;
      e = err ? a : '0;
      rv = '0;
      rv[p*DW +: DW] = d;
      return {rv, e, a};
   endfunction

   task automatic push_exp(input int p, input logic err, input logic [DW-1:0] d);
      if (use_fx) exp_fx_q.push_back(ack_rec(p, err, d));
      else        exp_rr_q.push_back(ack_rec(p, err, d));
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_port(input int p, input logic rd, input logic [SW-1:0] wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
      rd_tab[p]   = rd;
      wr_tab[p]   = wr;
      len_tab[p]  = LW'(p + 1);
      addr_tab[p] = a;
      wd_tab[p]   = wd;
      port_rd[p]  = rd;
      port_wr[p*SW +: SW]    = wr;
      port_len[p*LW +: LW]   = LW'(p + 1);
      port_addr[p*AW +: AW]  = a;
      port_wdata[p*DW +: DW] = wd;
   endtask

   // Entered just after the edge that starts port p's grant; returns just
   // after the edge that ends it. Ack comes in busy cycle dly+1.
   task automatic serve(input int p, input int dly, input logic [DW-1:0] d, input bit rereq);
      logic [NP-1:0] onehot;
      onehot = '0;
      onehot[p] = 1'b1;
      check("grant_busy",  RW'(s_busy),  RW'(1));
      check("grant_owner", RW'(s_owner), RW'(p));
      check("core_rd",     RW'(s_crd),   RW'(rd_tab[p]));
      check("core_wr",     RW'(s_cwr),   RW'(wr_tab[p]));
      check("core_len",    RW'(s_clen),  RW'(len_tab[p]));
      check("core_addr",   RW'(s_caddr), RW'(addr_tab[p]));
      check("core_wdata",  RW'(s_cwd),   RW'(wd_tab[p]));
      c_accept = 1'b1;
      #1;
      check("port_accept", RW'(s_accept), RW'(onehot));
      @(posedge clk); #1;
      c_accept = 1'b0;
      for (int i = 1; i < dly; i++) begin
         @(posedge clk); #1;
      end
      push_exp(p, 1'b0, d);
      c_ack   = 1'b1;
      c_rdata = d;
      @(posedge clk); #1;
      c_ack   = 1'b0;
      c_rdata = '0;
      if (!rereq) set_port(p, 1'b0, '0, addr_tab[p], wd_tab[p]);
   endtask

   // ---------------- scoreboard monitors ----------------
   // Every ack pulse must match the oldest predicted completion.
   always @(negedge clk) begin
      if (rr_ack != '0) begin
         if (exp_rr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rr_unexpected_ack ack=%b expected none", rr_ack);
         end else begin
            check("rr_ack_resp", {rr_rdata, rr_err, rr_ack}, exp_rr_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (fx_ack != '0) begin
         if (exp_fx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fx_unexpected_ack ack=%b expected none", fx_ack);
         end else begin
            check("fx_ack_resp", {fx_rdata, fx_err, fx_ack}, exp_fx_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_rr = 1'b1; rst_fx = 1'b1; use_fx = 1'b0;
      port_wr = '0; port_rd = '0; port_len = '0; port_addr = '0; port_wdata = '0;
      c_accept = 1'b0; c_ack = 1'b0; c_err = 1'b0; c_rdata = '0;
      for (int p = 0; p < NP; p++) set_port(p, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_rr = 1'b0;

      // Reset state.
      check("rst_busy",  RW'(s_busy),  RW'(0));
      check("rst_owner", RW'(s_owner), RW'(0));
      check("rst_core",  RW'({s_crd, s_cwr, s_caddr}), RW'(0));
      check("rst_ports", RW'({s_accept, s_ack, s_err, s_rdata}), RW'(0));

      // Single read on port 2; nothing reaches the core in the arbitration cycle.
      set_port(2, 1'b1, '0, 32'h100, '0);
      check("arb_cycle_busy",    RW'(s_busy), RW'(0));
      check("arb_cycle_core_rd", RW'(s_crd),  RW'(0));
      @(posedge clk); #1;
      serve(2, 5, 32'hDEADBEEF, 1'b0);
      check("p2_done_idle", RW'(s_busy), RW'(0));

      // Rotating order 0,1,3 from a fresh pointer, then again after wrap.
      rst_rr = 1'b1;
      @(posedge clk); #1;
      rst_rr = 1'b0;
      for (int round = 0; round < 2; round++) begin
         set_port(0, 1'b1, '0,       32'h200, '0);
         set_port(1, 1'b0, 4'b0011,  32'h300, 32'h1111_2222 + round);
         set_port(3, 1'b1, '0,       32'h400, '0);
         @(posedge clk); #1;
         serve(0, 3, 32'hA000_0000 + round, 1'b0);
         serve(1, 3, 32'hA100_0000 + round, 1'b0);
         serve(3, 3, 32'hA300_0000 + round, 1'b0);
         check("rr_round_idle", RW'(s_busy), RW'(0));
      end

      // Core responses while idle must not reach any port.
      c_ack = 1'b1; c_accept = 1'b1; c_err = 1'b1; c_rdata = 32'hFFFF_FFFF;
      #1;
      check("idle_ign_ports", RW'({s_accept, s_ack, s_err, s_rdata}), RW'(0));
      @(posedge clk); #1;
      check("idle_ign_busy",  RW'(s_busy), RW'(0));
      check("idle_ign_ports2", RW'({s_accept, s_ack, s_err, s_rdata}), RW'(0));
      c_ack = 1'b0; c_accept = 1'b0; c_err = 1'b0; c_rdata = '0;

      // Reset mid-burst while port 1 owns; pointer returns to port 0 first.
      set_port(1, 1'b1, '0, 32'h500, '0);
      @(posedge clk); #1;
      check("mid_owner", RW'(s_owner), RW'(1));
      @(posedge clk); #1;
      set_port(0, 1'b1, '0, 32'h600, '0);
      set_port(2, 1'b1, '0, 32'h700, '0);
      rst_rr = 1'b1;
      @(posedge clk); #1;
      rst_rr = 1'b0;
      check("mid_rst_busy",  RW'(s_busy),  RW'(0));
      check("mid_rst_owner", RW'(s_owner), RW'(0));
      check("mid_rst_core",  RW'({s_crd, s_cwr, s_caddr}), RW'(0));
      @(posedge clk); #1;
      serve(0, 2, 32'hB000_0000, 1'b0);
      serve(1, 2, 32'hB100_0000, 1'b0);
      serve(2, 2, 32'hB200_0000, 1'b0);
      check("mid_rst_idle", RW'(s_busy), RW'(0));

`ifdef SDRAM_ARB_TIMEOUT_EN
      // Core never acks port 1; watchdog completes it in the 16th busy cycle.
      check("tmo_clear", RW'(rr_timeout), RW'(0));
      set_port(1, 1'b1, '0, 32'h800, '0);
      set_port(2, 1'b1, '0, 32'h900, '0);
      @(posedge clk); #1;
      check("tmo_owner", RW'(s_owner), RW'(1));
      push_exp(1, 1'b1, '0);
      repeat (16) @(posedge clk);
      #1;
      set_port(1, 1'b0, '0, 32'h800, '0);
      check("tmo_sticky", RW'(rr_timeout), RW'(1));
      serve(2, 2, 32'hC200_0000, 1'b0);
`endif

      // Fixed priority: port 0 keeps re-requesting but never wins twice running.
      rst_rr = 1'b1;
      use_fx = 1'b1;
      rst_fx = 1'b0;
      set_port(0, 1'b1, '0, 32'h1000, '0);
      set_port(1, 1'b1, '0, 32'h1100, '0);
      set_port(3, 1'b1, '0, 32'h1300, '0);
      @(posedge clk); #1;
      serve(0, 3, 32'hD000_0001, 1'b1);
      serve(1, 3, 32'hD100_0001, 1'b0);
      serve(0, 3, 32'hD000_0002, 1'b1);
      serve(3, 3, 32'hD300_0001, 1'b0);
      serve(0, 3, 32'hD000_0003, 1'b0);
      check("fx_idle", RW'(s_busy), RW'(0));

      repeat (2) @(posedge clk);
      check("rr_queue_drained", RW'(exp_rr_q.size()), RW'(0));
      check("fx_queue_drained", RW'(exp_fx_q.size()), RW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
